bool_resp_checker: RTL and testbench

Response-side checker for the boolean-expression blocks: where a stimulus bench walks the input vectors {A,B,C,D} into a `boolN` expression, this block sits on the output side. It samples each (vector, F) pair and rebuilds the observed truth table. It compares that table against an expected table and reports coverage, mismatch count, first failing vector and a pass/fail verdict once every vector has been seen. It is synthesizable and is used both in benches and in on-chip self-test wrappers around the expression blocks.

---
 rtl/bool_resp_checker.sv | 117 +++++++++++
 tb/tb_bool_resp_checker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bool_resp_checker.sv
// Response-side checker for boolean-expression blocks: rebuilds the observed truth
// table from (vec, F) samples and scores it against an expected table.
module bool_resp_checker #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 5,
    parameter int TW    = 2 ** N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TW-1:0]    expected,
    input  logic             vec_valid,
    input  logic [N_IN-1:0]  vec,
    input  logic             F,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TW-1:0]    seen,
    output logic [TW-1:0]    captured,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_valid,
    output logic             dup_err,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] exp_q;

    // Handshake: vec_valid is a one-sided strobe with no ready. A (vec, F) pair is
    // consumed on every rising edge where vec_valid is high in CAPTURE and start is
    // low; start in the same cycle wins and the pair is dropped.
    logic          sample;
    logic [TW-1:0] vec_bit;
    logic [TW-1:0] seen_nxt;
    logic          mismatch;
    logic          dup_hit;

    always_comb begin
        sample   = 1'b0;
        vec_bit  = '0;
        seen_nxt = seen;
        mismatch = 1'b0;
        dup_hit  = 1'b0;
        sample   = (state_q == CAPTURE) && vec_valid && !start;
        vec_bit  = TW'(1) << vec;
        seen_nxt = seen | vec_bit;
        mismatch = (F != exp_q[vec]);
        dup_hit  = seen[vec] && (captured[vec] != F);
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = CAPTURE;
        end else if (sample && (&seen_nxt)) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q            <= '0;
            seen             <= '0;
            captured         <= '0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            dup_err          <= 1'b0;
        end else if (start) begin
            exp_q            <= expected;
            seen             <= '0;
            captured         <= '0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            dup_err          <= 1'b0;
        end else if (sample) begin
            seen          <= seen_nxt;
            captured[vec] <= F;
            if (dup_hit) begin
                dup_err <= 1'b1;
            end
            if (mismatch) begin
                // Duplicates can push the count past TW, so hold at all ones.
                if (mismatch_cnt != {CNT_W{1'b1}}) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!first_fail_valid) begin
                    first_fail       <= vec;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign pass      = done && (mismatch_cnt == '0) && !dup_err;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_bool_resp_checker.sv
// Directed bench for bool_resp_checker: hand-computed truth tables, coverage,
// failure reporting, duplicates, restart, reset and saturation.
module tb_bool_resp_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic        vec_valid;
    logic [3:0]  vec;
    logic        F;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] seen;
    logic [15:0] captured;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        first_fail_valid;
    logic        dup_err;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;

    bool_resp_checker #(.N_IN(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .vec_valid(vec_valid), .vec(vec), .F(F),
        .busy(busy), .done(done), .pass(pass), .seen(seen), .captured(captured),
        .mismatch_cnt(mismatch_cnt), .first_fail(first_fail),
        .first_fail_valid(first_fail_valid), .dup_err(dup_err), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Drivers change inputs 1ns after a rising edge and return 1ns after the next.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v, input logic f);
        vec_valid = 1'b1;
        vec       = v;
        F         = f;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] e);
        start    = 1'b1;
        expected = e;
        tick();
        start     = 1'b0;
        vec_valid = 1'b0;
    endtask

    logic [15:0] e;

    initial begin
        rst = 1'b1; start = 1'b0; expected = '0; vec_valid = 1'b0; vec = '0; F = 1'b0;

        // 1. reset with vec_valid toggling
        @(posedge clk); #1;
        vec_valid = 1'b1; vec = 4'd3; F = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_state", fsm_state, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_seen", seen, 16'h0000);
        check("rst_captured", captured, 16'h0000);
        check("rst_cnt", mismatch_cnt, 5'd0);
        check("rst_ff", {first_fail_valid, first_fail}, 5'd0);
        check("rst_dup", dup_err, 1'b0);
        send(4'd1, 1'b1);
        send(4'd2, 1'b0);
        check("idle_ignore_seen", seen, 16'h0000);

        // 2. clean sweep
        e = 16'hA5A5;
        do_start(e);
        check("sweep_busy", busy, 1'b1);
        for (int v = 0; v < 16; v++) begin
            send(4'(v), e[v]);
            if (v == 14) check("sweep_not_done_15", done, 1'b0);
        end
        check("sweep_done", done, 1'b1);
        check("sweep_busy_low", busy, 1'b0);
        check("sweep_pass", pass, 1'b1);
        check("sweep_cnt", mismatch_cnt, 5'd0);
        check("sweep_captured", captured, 16'hA5A5);
        check("sweep_seen", seen, 16'hFFFF);
        check("sweep_ffv", first_fail_valid, 1'b0);
        send(4'd0, ~e[0]);
        check("done_ignore_cnt", mismatch_cnt, 5'd0);
        check("done_ignore_cap", captured, 16'hA5A5);
        check("done_hold", done, 1'b1);

        // 3. failures at vectors 6 and 9
        do_start(e);
        for (int v = 0; v < 16; v++) begin
            send(4'(v), (v == 6 || v == 9) ? ~e[v] : e[v]);
        end
        check("fail_done", done, 1'b1);
        check("fail_cnt", mismatch_cnt, 5'd2);
        check("fail_first", first_fail, 4'd6);
        check("fail_ffv", first_fail_valid, 1'b1);
        check("fail_pass", pass, 1'b0);
        check("fail_captured", captured, 16'hA7E5);

        // 4. reverse order with a flipped duplicate of vector 3
        do_start(e);
        for (int v = 15; v >= 2; v--) send(4'(v), e[v]);
        send(4'd3, ~e[3]);
        send(4'd1, e[1]);
        check("rev_not_done", done, 1'b0);
        send(4'd0, e[0]);
        check("rev_done", done, 1'b1);
        check("rev_dup", dup_err, 1'b1);
        check("rev_cnt", mismatch_cnt, 5'd1);
        check("rev_first", first_fail, 4'd3);
        check("rev_pass", pass, 1'b0);
        check("rev_captured", captured, 16'hA5AD);

        // 5. restart mid-capture, colliding with a sample
        do_start(e);
        for (int v = 0; v < 5; v++) send(4'(v), ~e[v]);
        check("pre_restart_cnt", mismatch_cnt, 5'd5);
        vec_valid = 1'b1; vec = 4'd7; F = 1'b1;
        do_start(16'h00FF);
        check("restart_seen", seen, 16'h0000);
        check("restart_cnt", mismatch_cnt, 5'd0);
        check("restart_ffv", first_fail_valid, 1'b0);
        check("restart_busy", busy, 1'b1);
        for (int v = 0; v < 15; v++) send(4'(v), e[v]);
        check("restart_not_done", done, 1'b0);
        send(4'd15, e[15]);
        check("restart_done", done, 1'b1);
        check("restart_cnt_new", mismatch_cnt, 5'd8);
        check("restart_first", first_fail, 4'd1);

        // saturation via repeated mismatching samples
        do_start(16'h0000);
        for (int i = 0; i < 40; i++) send(4'd0, 1'b1);
        check("sat_cnt", mismatch_cnt, 5'd31);
        check("sat_dup", dup_err, 1'b0);
        check("sat_busy", busy, 1'b1);

        // 6. reset mid-capture after 8 vectors
        do_start(e);
        for (int v = 0; v < 8; v++) send(4'(v), e[v]);
        check("mid_seen", seen, 16'h00FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", fsm_state, 2'd0);
        check("midrst_seen", seen, 16'h0000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        for (int v = 0; v < 4; v++) send(4'(v), 1'b1);
        check("midrst_ignore", seen, 16'h0000);
        check("midrst_cap", captured, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
